// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-expansion word sequencer.
package aes_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRot,
        StSub,
        StRcon,
        StDone
    } state_e;

    localparam logic [7:0]  RCON_INIT          = 8'h01;
    localparam logic [7:0]  AES_POLY           = 8'h1B;
    localparam int unsigned NUM_ROUNDS_DEFAULT = 10;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/rcon_gen.sv
// Round constant and round counter for key expansion; wraps after NUM_ROUNDS rounds.
module rcon_gen
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       advance,
    output logic [7:0] rcon,
    output logic [3:0] round
);

    logic [7:0] rcon_q;
    logic [3:0] round_q;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            rcon_q  <= RCON_INIT;
            round_q <= 4'd0;
        end else if (advance) begin
            if (round_q == 4'(NUM_ROUNDS - 1)) begin
                rcon_q  <= RCON_INIT;
                round_q <= 4'd0;
            end else begin
                rcon_q  <= xtime(rcon_q);
                round_q <= round_q + 4'd1;
            end
        end
    end

    assign rcon  = rcon_q;
    assign round = round_q;

endmodule

// File: rtl/key_word_sequencer.sv
// Drives the column file through RotWord, SubWord and the Rcon XOR for one key word.
// Optional ack timeout enabled by defining KEY_SEQ_TIMEOUT_EN.
module key_word_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned NUM_ROUNDS  = NUM_ROUNDS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       init,
    input  logic [7:0] col_rdata1,
    input  logic [7:0] col_rdata2,
    input  logic [7:0] col_rdata3,
    input  logic [7:0] col_rdata4,
    output logic       col_load,
    output logic       col_wr,
    output logic [1:0] col_idx,
    output logic [7:0] col_wdata,
    output logic       sbox_req,
    output logic [7:0] sbox_addr,
    input  logic       sbox_ack,
    input  logic [7:0] sbox_data,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e     state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [7:0] sel_byte;
    logic       advance;
    logic       timeout;

`ifdef KEY_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts SUB cycles without ack for the current byte.
    assign timeout = (state_q == StSub) && !sbox_ack && (cnt_q == CntW'(ACK_TIMEOUT - 1));
    assign cnt_d   = ((state_q == StSub) && !sbox_ack && !timeout) ? cnt_q + CntW'(1)
                                                                    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        unique case (k_q)
            2'd0: sel_byte = col_rdata1;
            2'd1: sel_byte = col_rdata2;
            2'd2: sel_byte = col_rdata3;
            2'd3: sel_byte = col_rdata4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        col_load  = 1'b0;
        col_wr    = 1'b0;
        col_idx   = 2'd0;
        col_wdata = 8'h00;
        sbox_req  = 1'b0;
        sbox_addr = 8'h00;
        done      = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRot;
            end
            StRot: begin
                col_load = 1'b1;
                k_d      = 2'd0;
                state_d  = StSub;
            end
            StSub: begin
                sbox_req  = 1'b1;
                sbox_addr = sel_byte;
                if (sbox_ack) begin
                    col_wr    = 1'b1;
                    col_idx   = k_q;
                    col_wdata = sbox_data;
                    if (k_q == 2'd3) state_d = StRcon;
                    else             k_d     = k_q + 2'd1;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StRcon: begin
                col_wr    = 1'b1;
                col_idx   = 2'd0;
                col_wdata = col_rdata1 ^ rcon;
                state_d   = StDone;
            end
            StDone: begin
                done    = 1'b1;
                advance = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign err  = timeout;

    rcon_gen #(
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_rcon_gen (
        .clk     (clk),
        .rst     (rst),
        .init    (init && (state_q == StIdle)),
        .advance (advance),
        .rcon    (rcon),
        .round   (round)
    );

endmodule

// File: tb/tb_key_word_sequencer.sv
// Self-checking bench for key_word_sequencer with a GF(2^8) reference model.
module tb_key_word_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, init;
    logic [7:0] col_rdata1, col_rdata2, col_rdata3, col_rdata4;
    logic       col_load, col_wr;
    logic [1:0] col_idx;
    logic [7:0] col_wdata;
    logic       sbox_req;
    logic [7:0] sbox_addr;
    logic       sbox_ack;
    logic [7:0] sbox_data;
    logic [7:0] rcon;
    logic [3:0] round;
    logic       busy, done, err;

    int checks   = 0;
    int failures = 0;

    key_word_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init       (init),
        .col_rdata1 (col_rdata1),
        .col_rdata2 (col_rdata2),
        .col_rdata3 (col_rdata3),
        .col_rdata4 (col_rdata4),
        .col_load   (col_load),
        .col_wr     (col_wr),
        .col_idx    (col_idx),
        .col_wdata  (col_wdata),
        .sbox_req   (sbox_req),
        .sbox_addr  (sbox_addr),
        .sbox_ack   (sbox_ack),
        .sbox_data  (sbox_data),
        .rcon       (rcon),
        .round      (round),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0]  inv = 8'h01;
        logic [15:0] d;
        logic [7:0]  s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        s = inv ^ 8'h63;
        for (int n = 1; n <= 4; n++) begin
            d = {inv, inv} << n;
            s = s ^ d[15:8];
        end
        return s;
    endfunction

    function automatic logic [7:0] rcon_ref(input int r);
        logic [7:0] p = 8'h01;
        for (int i = 0; i < r; i++) p = gmul(p, 8'h02);
        return p;
    endfunction

    // Word packed {byte0, byte1, byte2, byte3}.
    function automatic logic [31:0] temp_ref(input logic [31:0] w, input logic [7:0] rc);
        return {sbox_f(w[23:16]) ^ rc, sbox_f(w[15:8]), sbox_f(w[7:0]), sbox_f(w[31:24])};
    endfunction

    // ---------------- column file model ----------------
    logic [7:0]  colf [4];
    logic        load_req = 1'b0;
    logic [31:0] load_word = 32'h0;

    always @(posedge clk) begin
        if (load_req) begin
            colf[0] <= load_word[31:24];
            colf[1] <= load_word[23:16];
            colf[2] <= load_word[15:8];
            colf[3] <= load_word[7:0];
        end else if (col_load) begin
            colf[0] <= colf[1];
            colf[1] <= colf[2];
            colf[2] <= colf[3];
            colf[3] <= colf[0];
        end else if (col_wr) begin
            colf[col_idx] <= col_wdata;
        end
    end

    assign col_rdata1 = colf[0];
    assign col_rdata2 = colf[1];
    assign col_rdata3 = colf[2];
    assign col_rdata4 = colf[3];

    function automatic logic [31:0] file_word();
        return {colf[0], colf[1], colf[2], colf[3]};
    endfunction

    // ---------------- S-box responder ----------------
    int ack_delay = 0;
    int wait_cnt  = 0;
    bit ack_hold  = 1'b0;
    bit stray     = 1'b0;

    initial begin
        sbox_ack  = 1'b0;
        sbox_data = 8'h00;
    end

    always @(negedge clk) begin
        if (sbox_req && !ack_hold) begin
            if (wait_cnt >= ack_delay) begin
                sbox_ack  = 1'b1;
                sbox_data = sbox_f(sbox_addr);
                wait_cnt  = 0;
            end else begin
                sbox_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            sbox_ack  = stray;
            sbox_data = 8'hA5;
            wait_cnt  = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] w);
        @(negedge clk);
        load_word = w;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
    endtask

    logic [7:0] addr_q[$];
    int         overlap, busy_bad, unstable;

    // Issues start (optionally with init) and follows the transform until done.
    task automatic run_word(input bit with_init, input bit noise, output int lat);
        logic       prev_wait = 1'b0;
        logic [7:0] prev_addr = 8'h00;
        lat = -1;
        overlap = 0; busy_bad = 0; unstable = 0;
        addr_q.delete();
        @(negedge clk);
        start = 1'b1;
        init  = with_init;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            init  = 1'b0;
            #1;
            if (col_load && col_wr) overlap++;
            if (!busy) busy_bad++;
            if (prev_wait && sbox_req && sbox_addr != prev_addr) unstable++;
            if (sbox_req && sbox_ack) addr_q.push_back(sbox_addr);
            prev_wait = sbox_req && !sbox_ack;
            prev_addr = sbox_addr;
            if (done) begin
                lat = cyc;
                break;
            end
            if (noise) begin
                start = 1'($urandom);
                init  = 1'($urandom);
            end
        end
    endtask

    int          lat;
    int          ref_round;
    logic [7:0]  ref_rcon;
    logic [31:0] w;
    logic [31:0] addrs;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        init  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", {col_load, col_wr, col_idx, sbox_req, busy, done, err}, 0);
        chk("rst_data", {col_wdata, sbox_addr}, 0);
        chk("rst_rcon", rcon, 8'h01);
        chk("rst_round", round, 0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 word, ack in the request cycle.
        load(32'h09CF4F3C);
        ack_delay = 0;
        run_word(1'b0, 1'b0, lat);
        chk("fips_lat", lat, 7);
        chk("fips_word", file_word(), 32'h8B84EB01);
        chk("fips_model", file_word(), temp_ref(32'h09CF4F3C, 8'h01));
        chk("fips_busy", busy_bad, 0);
        chk("fips_overlap", overlap, 0);
        @(negedge clk); #1;
        chk("fips_rcon", rcon, 8'h02);
        chk("fips_round", round, 1);
        chk("fips_idle", {busy, done}, 0);

        // Same word, ack delayed 3 cycles, init together with start.
        load(32'h09CF4F3C);
        ack_delay = 3;
        run_word(1'b1, 1'b0, lat);
        chk("slow_lat", lat, 19);
        chk("slow_word", file_word(), 32'h8B84EB01);
        addrs = (addr_q.size() == 4) ? {addr_q[0], addr_q[1], addr_q[2], addr_q[3]} : 32'h0;
        chk("slow_addr_order", addrs, 32'hCF4F3C09);
        chk("slow_addr_stable", unstable, 0);
        chk("slow_busy", busy_bad, 0);
        @(negedge clk); #1;
        chk("slow_rcon", rcon, 8'h02);

        // Ten back-to-back random words after init.
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        #1;
        chk("init_rcon", rcon, 8'h01);
        chk("init_round", round, 0);
        ref_round = 0;
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            load(w);
            ack_delay = $urandom_range(0, 2);
            ref_rcon = rcon_ref(ref_round);
            #1;
            chk("seq_rcon", rcon, ref_rcon);
            chk("seq_round", round, ref_round);
            run_word(1'b0, 1'b0, lat);
            chk("seq_done", lat > 0, 1);
            chk("seq_word", file_word(), temp_ref(w, ref_rcon));
            chk("seq_overlap", overlap, 0);
            ref_round = (ref_round + 1) % 10;
        end
        @(negedge clk); #1;
        chk("wrap_rcon", rcon, 8'h01);
        chk("wrap_round", round, 0);

        // start/init noise while busy must be ignored.
        w = $urandom;
        load(w);
        ack_delay = 1;
        run_word(1'b0, 1'b1, lat);
        chk("noise_word", file_word(), temp_ref(w, 8'h01));
        start = 1'b0;
        init  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("noise_single_done", {busy, done}, 0);
        end
        chk("noise_rcon", rcon, 8'h02);
        chk("noise_round", round, 1);

        // Reset in SUB at byte 2.
        load($urandom);
        ack_delay = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("pre_rst_in_sub", sbox_req, 1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_ctrl", {col_load, col_wr, col_idx, sbox_req, busy, done, err}, 0);
        chk("mid_rst_data", {col_wdata, sbox_addr}, 0);
        chk("mid_rst_rcon", rcon, 8'h01);
        chk("mid_rst_round", round, 0);
        rst = 1'b0;
        w = $urandom;
        load(w);
        ack_delay = 2;
        run_word(1'b0, 1'b0, lat);
        chk("post_rst_lat", lat, 15);
        chk("post_rst_word", file_word(), temp_ref(w, 8'h01));

        // Stray ack in IDLE has no effect.
        @(negedge clk);
        stray = 1'b1;
        w = file_word();
        repeat (3) @(negedge clk);
        #1;
        chk("stray_idle", {busy, col_wr, col_load, done, err}, 0);
        stray = 1'b0;
        @(negedge clk); #1;
        chk("stray_file", file_word(), w);

`ifdef KEY_SEQ_TIMEOUT_EN
        begin
            int err_cyc = -1;
            int dones   = 0;
            ref_rcon = rcon;
            ack_hold = 1'b1;
            @(negedge clk);
            start = 1'b1;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                if (done) dones++;
                if (err && err_cyc < 0) err_cyc = cyc;
            end
            ack_hold = 1'b0;
            chk("timeout_err_cycle", err_cyc, 17);
            chk("timeout_no_done", dones, 0);
            chk("timeout_idle", busy, 0);
            chk("timeout_rcon", rcon, ref_rcon);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
